// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pipe_pkg                                                  |
// | Purpose  : Shared types and constants for the pipeline stall control |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MD_WAIT  = 2'd2,
        ST_MEM_WAIT = 2'd3
    } pipe_state_t;

    localparam int c_mul_lat_def = 4;
    localparam int c_div_lat_def = 16;

    // Stall causes, listed from highest to lowest priority.
    typedef enum logic [2:0] {
        CAUSE_NONE   = 3'd0,
        CAUSE_DMEM   = 3'd1,
        CAUSE_MD     = 3'd2,
        CAUSE_HOLD   = 3'd3,
        CAUSE_BRANCH = 3'd4,
        CAUSE_IMEM   = 3'd5
    } stall_cause_t;

    function automatic stall_cause_t run_cause(
        input logic dmem_miss,
        input logic md_start,
        input logic hold,
        input logic branch_redirect,
        input logic imem_ready
    );
        if (dmem_miss)            return CAUSE_DMEM;
        else if (md_start)        return CAUSE_MD;
        else if (hold)            return CAUSE_HOLD;
        else if (branch_redirect) return CAUSE_BRANCH;
        else if (!imem_ready)     return CAUSE_IMEM;
        else                      return CAUSE_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stall_ctrl_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sat_counter                                               |
// | Purpose  : Saturating up-counter with synchronous clear              |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // Clear outranks increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_count <= '0;
        else if (clr)
            r_count <= '0;
        else if (inc && (r_count != '1))
            r_count <= r_count + WIDTH'(1);
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pipe_stall_ctrl                                           |
// | Purpose  : Stall/flush sequencer driving all pipeline-register       |
// |            enables, flushes and the stall-cycle counter              |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module pipe_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int MUL_LAT = c_mul_lat_def,
    parameter int DIV_LAT = c_div_lat_def,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        branch_redirect,
    input  logic        md_start,
    input  logic        md_is_div,
    input  logic        imem_ready,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    input  logic        perf_clr,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cycles
);

    // The start cycle and the done cycle are both part of EX occupancy.
    localparam logic [CNT_W-1:0] c_mul_load = CNT_W'(MUL_LAT - 2);
    localparam logic [CNT_W-1:0] c_div_load = CNT_W'(DIV_LAT - 2);

    pipe_state_t      r_state;
    pipe_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_lat_cnt;
    logic [CNT_W-1:0] w_lat_cnt_nxt;
    logic             w_dmem_miss;
    logic             w_stall_inc;
    stall_cause_t     w_cause;

    assign w_dmem_miss = dmem_req && !dmem_ready;
    assign w_cause     = run_cause(w_dmem_miss, md_start, hold, branch_redirect, imem_ready);

    always_comb begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
        {ifid_flush, idex_flush, exmem_flush}          = 3'b000;
        md_busy       = 1'b0;
        md_done       = 1'b0;
        w_state_nxt   = r_state;
        w_lat_cnt_nxt = r_lat_cnt;
        case (r_state)
            ST_INIT: begin
                {ifid_flush, idex_flush, exmem_flush} = 3'b111;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                case (w_cause)
                    CAUSE_DMEM: begin
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
                        w_state_nxt = ST_MEM_WAIT;
                    end
                    CAUSE_MD: begin
                        {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
                        exmem_flush   = 1'b1;
                        w_lat_cnt_nxt = md_is_div ? c_div_load : c_mul_load;
                        w_state_nxt   = ST_MD_WAIT;
                    end
                    CAUSE_HOLD: begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                    CAUSE_BRANCH: ifid_flush = 1'b1;
                    CAUSE_IMEM: begin
                        pc_en      = 1'b0;
                        ifid_flush = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MD_WAIT: begin
                md_busy = 1'b1;
                if (r_lat_cnt == '0) begin
                    // Result is ready: pipeline advances unless MEM is still missing.
                    md_done = 1'b1;
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = {5{!w_dmem_miss}};
                    w_state_nxt = w_dmem_miss ? ST_MEM_WAIT : ST_RUN;
                end else begin
                    exmem_flush   = 1'b1;
                    memwb_en      = !w_dmem_miss;
                    w_lat_cnt_nxt = r_lat_cnt - CNT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_INIT;
            r_lat_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lat_cnt <= w_lat_cnt_nxt;
        end
    end

    assign w_stall_inc = !pc_en && (r_state != ST_INIT);

    sat_counter #(
        .WIDTH (32)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall_inc),
        .clr   (perf_clr),
        .count (stall_cycles)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_pipe_stall_ctrl                                        |
// | Purpose  : Self-checking bench for pipe_stall_ctrl                   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_pipe_stall_ctrl;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold = 0, branch_redirect = 0, md_start = 0, md_is_div = 0;
    logic        imem_ready = 1, dmem_req = 0, dmem_ready = 1, perf_clr = 0;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, md_busy, md_done;
    logic [31:0] stall_cycles;
    logic        sat_inc = 0, sat_clr = 0;
    logic [3:0]  sat_count;

    int n_checks = 0;
    int n_errors = 0;

    pipe_stall_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .hold(hold), .branch_redirect(branch_redirect),
        .md_start(md_start), .md_is_div(md_is_div), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .perf_clr(perf_clr),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .md_busy(md_busy), .md_done(md_done),
        .stall_cycles(stall_cycles)
    );

    // Narrow instance so saturation is reachable in a short run.
    sat_counter #(.WIDTH(4)) u_sat (
        .clk(clk), .rst(rst), .inc(sat_inc), .clr(sat_clr), .count(sat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // {pc,ifid,idex,exmem,memwb, ifid_fl,idex_fl,exmem_fl, busy,done}
    function automatic logic [9:0] dut_ctrl();
        return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, exmem_flush, md_busy, md_done};
    endfunction

    // Behavioural model: "just reset", remaining md cycles, waiting on memory.
    bit          m_init = 1, n_init = 1;
    int          m_md_left = 0, n_md_left = 0;
    bit          m_mem = 0, n_mem = 0;
    logic [31:0] m_stall = 0, n_stall = 0;

    function automatic logic [9:0] model_ctrl();
        logic miss;
        miss = dmem_req && !dmem_ready;
        if (m_init) return 10'b00000_111_00;
        if (m_md_left > 0) begin
            if (m_md_left == 1) return miss ? 10'b00000_000_11 : 10'b11111_000_11;
            return {4'b0000, !miss, 3'b001, 2'b10};
        end
        if (m_mem) return dmem_ready ? 10'b11111_000_00 : 10'b00000_000_00;
        if (miss) return 10'b00000_000_00;
        if (md_start) return 10'b00001_001_00;
        if (hold) return 10'b00111_010_00;
        if (branch_redirect) return 10'b11111_100_00;
        if (!imem_ready) return 10'b01111_100_00;
        return 10'b11111_000_00;
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            logic [9:0] e;
            logic       miss;
            miss = dmem_req && !dmem_ready;
            e = model_ctrl();
            chk("ctrl", {22'b0, dut_ctrl()}, {22'b0, e});
            chk("stall_cycles", stall_cycles, m_stall);
            n_init = 0; n_md_left = m_md_left; n_mem = m_mem;
            if (m_init) begin
            end else if (m_md_left > 0) begin
                if (m_md_left == 1) begin
                    n_md_left = 0;
                    n_mem = miss;
                end else n_md_left = m_md_left - 1;
            end else if (m_mem) begin
                if (dmem_ready) n_mem = 0;
            end else if (miss) n_mem = 1;
            else if (md_start) n_md_left = md_is_div ? DIV_LAT - 1 : MUL_LAT - 1;
            if (perf_clr) n_stall = 0;
            else if (!e[9] && !m_init && m_stall != 32'hFFFF_FFFF) n_stall = m_stall + 1;
            else n_stall = m_stall;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_init <= 1; m_md_left <= 0; m_mem <= 0; m_stall <= 0;
        end else begin
            m_init <= n_init; m_md_left <= n_md_left; m_mem <= n_mem; m_stall <= n_stall;
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("async_init_flush", {29'b0, ifid_flush, idex_flush, exmem_flush}, 32'h7);
        chk("async_init_pc", {31'b0, pc_en}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #3 chk("init_flushes", {29'b0, ifid_flush, idex_flush, exmem_flush}, 32'h7);
        chk("init_enables", {27'b0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 32'h0);
        next(); #3;
        chk("run_enables", {27'b0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 32'h1F);
        chk("run_stall0", stall_cycles, 32'd0);

        // hold for one cycle
        next(); hold = 1; #3;
        chk("hold_pc_ifid", {30'b0, pc_en, ifid_en}, 32'h0);
        chk("hold_idex_flush", {31'b0, idex_flush}, 32'h1);
        next(); hold = 0; #3;
        chk("hold_stall1", stall_cycles, 32'd1);

        // multiply; md_start stays up while frozen in EX
        next(); md_start = 1; md_is_div = 0; #3;
        chk("mul_t_ctrl", {22'b0, dut_ctrl()}, {22'b0, 10'b00001_001_00});
        next(); #3 chk("mul_t1_busy_done", {30'b0, md_busy, md_done}, 32'h2);
        next(); #3 chk("mul_t2_pc", {31'b0, pc_en}, 32'h0);
        next(); #3 chk("mul_t3_done_pc", {30'b0, md_done, pc_en}, 32'h3);
        chk("mul_stall4", stall_cycles, 32'd4);
        next(); md_start = 0; #3 chk("mul_t4_busy", {31'b0, md_busy}, 32'h0);

        // divide
        next(); md_start = 1; md_is_div = 1; #3;
        for (int k = 1; k <= 15; k++) begin
            next(); md_start = 0; #3;
            chk("div_done", {31'b0, md_done}, (k == 15) ? 32'h1 : 32'h0);
        end
        next(); #3 chk("div_after_busy", {31'b0, md_busy}, 32'h0);

        // dmem miss spanning the multiply completion
        next(); md_start = 1; md_is_div = 0; #3;
        next(); md_start = 0; dmem_req = 1; dmem_ready = 0; #3;
        chk("mdmiss_memwb", {30'b0, memwb_en, md_busy}, 32'h1);
        next(); #3;
        next(); #3 chk("mdmiss_done", {22'b0, dut_ctrl()}, {22'b0, 10'b00000_000_11});
        next(); #3 chk("memwait_idle", {27'b0, pc_en, memwb_en, exmem_en, md_busy, md_done}, 32'h0);
        next(); dmem_ready = 1; #3;
        chk("memwait_exit", {27'b0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 32'h1F);
        next(); dmem_req = 0; #3;

        // dmem miss outranks md_start in RUN
        next(); dmem_req = 1; dmem_ready = 0; md_start = 1; #3;
        chk("miss_over_md", {22'b0, dut_ctrl()}, 32'h0);
        next(); #3 chk("miss_no_busy", {31'b0, md_busy}, 32'h0);
        next(); dmem_ready = 1; md_start = 0; #3;
        chk("miss_exit", {27'b0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 32'h1F);
        next(); dmem_req = 0;

        // branch vs imem wait, hold vs branch
        branch_redirect = 1; imem_ready = 0; #3;
        chk("br_over_imem", {30'b0, pc_en, ifid_flush}, 32'h3);
        next(); hold = 1; #3;
        chk("hold_over_br", {29'b0, pc_en, idex_flush, ifid_flush}, 32'h2);
        next(); hold = 0; branch_redirect = 0; #3;
        chk("imem_wait", {29'b0, pc_en, ifid_en, ifid_flush}, 32'h3);
        next(); imem_ready = 1;

        // perf_clr beats a concurrent stall
        hold = 1; perf_clr = 1; #3;
        next(); hold = 0; perf_clr = 0; #3 chk("perf_clr", stall_cycles, 32'd0);

        // async reset in the middle of a divide
        next(); md_start = 1; md_is_div = 1; #3;
        next(); md_start = 0; #3 chk("div_busy_pre_rst", {31'b0, md_busy}, 32'h1);
        @(posedge clk); #2 rst = 0;
        #1 chk("rst_busy_drop", {31'b0, md_busy}, 32'h0);
        chk("rst_stall_zero", stall_cycles, 32'd0);
        chk("rst_flushes", {29'b0, ifid_flush, idex_flush, exmem_flush}, 32'h7);
        @(posedge clk); #1 rst = 1;
        #3 chk("rst_init_again", {22'b0, dut_ctrl()}, {22'b0, 10'b00000_111_00});
        next(); #3 chk("rst_run_again", {22'b0, dut_ctrl()}, {22'b0, 10'b11111_000_00});

        // saturation on a narrow counter
        sat_inc = 1;
        for (int i = 1; i <= 18; i++) begin
            next(); #3;
            chk("sat_count", {28'b0, sat_count}, (i > 15) ? 32'd15 : i);
        end
        sat_clr = 1;
        next(); #3 chk("sat_clr", {28'b0, sat_count}, 32'd0);
        sat_clr = 0; sat_inc = 0;

        next(); next();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central stall/flush sequencer for the 5-stage pipeline. Merges the hazard unit's requests (`hold`, branch redirect) with multi-cycle multiply/divide occupancy and instruction/data memory wait states. Drives per-stage pipeline-register enables and flushes, and keeps a saturating stall-cycle counter. Sits beside the hazard detection logic; every IF/ID, ID/EX, EX/MEM and MEM/WB register and the PC take their enable/flush only from this block.

## Interface
- `MUL_LAT`, 4, multiply latency in cycles (≥2)
- `DIV_LAT`, 16, divide latency in cycles (≥2, ≥ MUL_LAT)
- `CNT_W`, 5, latency counter width; must hold DIV_LAT-1
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `hold`  in  1  load-use / branch-operand stall request from hazard unit
- `branch_redirect`  in  1  taken branch or jump resolved in ID
- `md_start`  in  1  mult/div instruction in EX this cycle
- `md_is_div`  in  1  qualifies `md_start`: 1 = divide
- `imem_ready`  in  1  instruction fetch data valid
- `dmem_req`  in  1  load/store in MEM
- `dmem_ready`  in  1  data memory access complete
- `perf_clr`  in  1  synchronous clear of `stall_cycles`
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en`  out  1 each  register enables
- `ifid_flush`, `idex_flush`, `exmem_flush`  out  1 each  load bubble into that register
- `md_busy`  out  1  mult/div unit occupied
- `md_done`  out  1  one-cycle pulse: mult/div result valid in EX
- `stall_cycles`  out  32  count of cycles with `pc_en`=0 outside INIT

## Operation
- States: INIT, RUN, MD_WAIT, MEM_WAIT. Reset → INIT. INIT always → RUN next cycle.
- INIT: all enables 0; `ifid_flush`=`idex_flush`=`exmem_flush`=1; `md_busy`=`md_done`=0.
- RUN: enables default 1, flushes 0. Conditions are evaluated in priority order and the first match applies:
  1. `dmem_req && !dmem_ready`: all enables 0. Next state MEM_WAIT.
  2. `md_start`: `pc_en`=`ifid_en`=`idex_en`=`exmem_en`=0; `exmem_flush`=1; `memwb_en`=1. Load counter with (`md_is_div` ? DIV_LAT : MUL_LAT) − 2. Next state MD_WAIT.
  3. `hold`: `pc_en`=`ifid_en`=0; `idex_flush`=1.
  4. `branch_redirect`: `pc_en`=1 (loads target); `ifid_flush`=1. Overrides `imem_ready`=0.
  5. `!imem_ready`: `pc_en`=0; `ifid_flush`=1.
- MD_WAIT: `md_busy`=1. Same enables as RUN rule 2, except `memwb_en` = !(`dmem_req && !dmem_ready`). Counter decrements every cycle and is never frozen.
  - At counter = 0: `md_done`=1 and all enables return to RUN rule-1 values.
  - Next state is MEM_WAIT if a dmem miss is active, else RUN.
- MEM_WAIT: all enables 0, flushes 0. Exits to RUN on the cycle `dmem_ready`=1; that cycle's outputs equal RUN with the miss cleared.
- Outputs are Mealy (state + current inputs); state and counters are registered.
- `stall_cycles`: +1 every cycle `pc_en`=0 and state≠INIT. Saturates at 0xFFFF_FFFF. `perf_clr` has priority over the increment. Reset value 0.

## Timing
- All flushes/enables act on the same clock edge as the cycle they are asserted.
- MUL: `md_start` at cycle t → `md_done` at t+MUL_LAT−1 → pipeline advances on that edge. EX occupancy is exactly MUL_LAT cycles; DIV likewise with DIV_LAT.
- `md_start` is ignored in MD_WAIT and MEM_WAIT; the EX instruction is frozen, so it is re-presented after the wait.
- `hold` and `branch_redirect` are ignored outside RUN.
- Reset asserted mid-MD_WAIT or mid-MEM_WAIT → INIT immediately: counter 0, `md_busy` 0, `stall_cycles` 0.
- Reset values: state INIT, counter 0, `stall_cycles` 0; outputs per INIT.

## Structure
- Shared package `pipe_pkg` holds: the state enum (2-bit, INIT=0), the default MUL_LAT/DIV_LAT constants, and the stall-cause encoding for the priority order.
- One sub-module: `sat_counter`, parameterised width with `inc`/`clr`, used for `stall_cycles`.
- FSM and latency counter stay in the top module.

## Test plan
- Reset, then release: one INIT cycle with all flushes 1, then RUN with all enables 1 and `stall_cycles`=0.
- `hold`=1 for 1 cycle in RUN → `pc_en`=`ifid_en`=0, `idex_flush`=1; `stall_cycles` becomes 1.
- `md_start`=1, `md_is_div`=0 at t → `md_busy` high for t+1..t+3, `md_done` pulse at t+3, `pc_en` 0 for t..t+2; repeat with divide → `md_done` at t+15.
- MD_WAIT with dmem miss (`dmem_req`=1, `dmem_ready`=0) covering the done cycle → `md_done` still pulses, `memwb_en`=0, next state MEM_WAIT. When `dmem_ready`=1, all enables = 1.
- `branch_redirect`=1 together with `imem_ready`=0 → `pc_en`=1, `ifid_flush`=1; `branch_redirect` together with `hold` → hold wins: `pc_en`=0, `idex_flush`=1.
- Preload `stall_cycles` near 0xFFFF_FFFF via a long stall → stays at saturation. `perf_clr` together with a stall → reads 0 next cycle. Async reset mid-divide → `md_busy` drops without waiting for a clock.
